// File: rtl/sdr_sync_pkg.sv
// -----------------------------------------------------------------------------
// sdr_sync_pkg
// Shared definitions for the frame/symbol-sync detector of the SDR demod path.
//   IDX_W    : width of the free-running sample index
//   SCORE_W  : width of one dual-MAC correlation score
//   sync_state_e : detector FSM states (also exported on the debug port)
// -----------------------------------------------------------------------------
package sdr_sync_pkg;

   localparam int IDX_W   = 16;
   localparam int SCORE_W = 22;

   typedef enum logic [2:0] {
      ST_FILL    = 3'd0,
      ST_SEARCH  = 3'd1,
      ST_TRACK   = 3'd2,
      ST_REPORT  = 3'd3,
      ST_HOLDOFF = 3'd4
   } sync_state_e;

endpackage

// File: rtl/win_sum.sv
// -----------------------------------------------------------------------------
// win_sum
// Sliding-window sum over the last 2**WIN_LOG2 accepted scores.
//   clk, rst   : clock, synchronous active-high reset
//   sum_valid  : a score is presented and accepted this cycle
//   sum_in     : unsigned score
//   acc        : registered window sum (includes the newest accepted score)
//   acc_valid  : one-cycle pulse, the cycle after an accept, once the window
//                holds a full set of samples
//   win_full   : window has seen at least 2**WIN_LOG2 samples since reset
// -----------------------------------------------------------------------------
module win_sum #(
   parameter int SUM_W    = 22,
   parameter int WIN_LOG2 = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sum_valid,
   input  logic [SUM_W-1:0]          sum_in,
   output logic [SUM_W+WIN_LOG2-1:0] acc,
   output logic                      acc_valid,
   output logic                      win_full
);

   localparam int                WIN      = 1 << WIN_LOG2;
   localparam int                ACC_W    = SUM_W + WIN_LOG2;
   localparam logic [WIN_LOG2:0] FILL_MAX = (WIN_LOG2 + 1)'(WIN);

   logic [SUM_W-1:0]  r_line [WIN];
   logic [ACC_W-1:0]  r_acc;
   logic [WIN_LOG2:0] r_fill;
   logic              r_new;
   logic              w_full;

   assign w_full = (r_fill == FILL_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the delay line is reset too, because the accumulator subtracts
         // its oldest entry; stale contents would corrupt the sum after reset.
         for (int i = 0; i < WIN; i++) r_line[i] <= '0;
         r_acc  <= '0;
         r_fill <= '0;
         r_new  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here sees the
         // pre-edge values; the shift and the accumulator both rely on that.
         r_new <= sum_valid;
         if (sum_valid) begin
            r_line[0] <= sum_in;
            for (int i = 1; i < WIN; i++) r_line[i] <= r_line[i-1];
            // Modular add/subtract is exact: the true sum fits in ACC_W bits.
            r_acc <= r_acc + ACC_W'(sum_in) - ACC_W'(r_line[WIN-1]);
            if (!w_full) r_fill <= r_fill + 1'b1;
         end
      end
   end

   assign acc       = r_acc;
   assign win_full  = w_full;
   assign acc_valid = r_new && w_full;

endmodule

// File: rtl/mac_score_detector.sv
// -----------------------------------------------------------------------------
// mac_score_detector
// Smooths dual-MAC correlation scores with a sliding-window sum, detects
// threshold crossings, tracks the peak of each crossing and hands the peak
// value and its sample index to a consumer over valid/ready.
//   clk, rst   : clock, synchronous active-high reset
//   sum_valid  : score present (always accepted, no backpressure)
//   sum_in     : unsigned score
//   det_valid  : report available, held until det_ready
//   det_ready  : consumer accepts the report
//   det_peak   : peak window sum of the event
//   det_index  : index of the newest sample in the peak window
//   det_forced : event ended by the track-length limit, not by the threshold
//   state_o    : current FSM state (debug)
// -----------------------------------------------------------------------------
module mac_score_detector
   import sdr_sync_pkg::*;
#(
   parameter int                        SUM_W     = SCORE_W,
   parameter int                        WIN_LOG2  = 3,
   parameter logic [SUM_W+WIN_LOG2-1:0] THRESH    = 100000,
   parameter int                        HOLDOFF   = 16,
   parameter int                        MAX_TRACK = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sum_valid,
   input  logic [SUM_W-1:0]          sum_in,
   output logic                      det_valid,
   input  logic                      det_ready,
   output logic [SUM_W+WIN_LOG2-1:0] det_peak,
   output logic [IDX_W-1:0]          det_index,
   output logic                      det_forced,
   output logic [2:0]                state_o
);

   localparam int             ACC_W      = SUM_W + WIN_LOG2;
   localparam int             CNT_W      = 8;
   localparam logic [CNT_W-1:0] TRACK_LAST = CNT_W'(MAX_TRACK - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);

   logic [ACC_W-1:0] w_acc;
   logic             w_acc_valid;
   logic             w_win_full;
   logic             w_above;
   logic [IDX_W-1:0] w_cur_idx;

   sync_state_e      r_state,    w_state_nxt;
   logic [IDX_W-1:0] r_index;
   logic [ACC_W-1:0] r_peak,     w_peak_nxt;
   logic [IDX_W-1:0] r_peak_idx, w_peak_idx_nxt;
   logic             r_forced,   w_forced_nxt;
   // Track length in TRACK, samples consumed in HOLDOFF; never both at once.
   logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;

   win_sum #(
      .SUM_W    (SUM_W),
      .WIN_LOG2 (WIN_LOG2)
   ) u_win_sum (
      .clk       (clk),
      .rst       (rst),
      .sum_valid (sum_valid),
      .sum_in    (sum_in),
      .acc       (w_acc),
      .acc_valid (w_acc_valid),
      .win_full  (w_win_full)
   );

   assign w_above   = (w_acc >= THRESH);
   // Compares run the cycle after the accept, when r_index has already moved
   // on by exactly one, so the sample behind w_acc is r_index - 1.
   assign w_cur_idx = r_index - 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_FILL;
         r_index    <= '0;
         r_peak     <= '0;
         r_peak_idx <= '0;
         r_forced   <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_peak     <= w_peak_nxt;
         r_peak_idx <= w_peak_idx_nxt;
         r_forced   <= w_forced_nxt;
         r_cnt      <= w_cnt_nxt;
         if (sum_valid) r_index <= r_index + 1'b1;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      w_state_nxt    = r_state;
      w_peak_nxt     = r_peak;
      w_peak_idx_nxt = r_peak_idx;
      w_forced_nxt   = r_forced;
      w_cnt_nxt      = r_cnt;

      case (r_state)
         ST_FILL, ST_SEARCH: begin
            // The first full window is compared in the same cycle FILL is
            // left, so a score already above threshold at fill time counts.
            if (w_win_full) w_state_nxt = ST_SEARCH;
            if (w_acc_valid && w_above) begin
               w_state_nxt    = ST_TRACK;
               w_peak_nxt     = w_acc;
               w_peak_idx_nxt = w_cur_idx;
               w_cnt_nxt      = CNT_W'(1);
            end
         end

         ST_TRACK: begin
            if (w_acc_valid) begin
               if (!w_above) begin
                  w_state_nxt  = ST_REPORT;
                  w_forced_nxt = 1'b0;
               end else begin
                  // Strict compare: on equal sums the earliest index is kept.
                  if (w_acc > r_peak) begin
                     w_peak_nxt     = w_acc;
                     w_peak_idx_nxt = w_cur_idx;
                  end
                  w_cnt_nxt = r_cnt + 1'b1;
                  if (r_cnt >= TRACK_LAST) begin
                     w_state_nxt  = ST_REPORT;
                     w_forced_nxt = 1'b1;
                  end
               end
            end
         end

         ST_REPORT: begin
            if (det_ready) begin
               w_state_nxt = ST_HOLDOFF;
               w_cnt_nxt   = '0;
            end
         end

         ST_HOLDOFF: begin
            if (w_acc_valid) begin
               if (r_cnt == HOLD_LAST) w_state_nxt = ST_SEARCH;
               else                    w_cnt_nxt   = r_cnt + 1'b1;
            end
         end

         default: w_state_nxt = ST_FILL;
      endcase
   end

   assign det_valid  = (r_state == ST_REPORT);
   assign det_peak   = r_peak;
   assign det_index  = r_peak_idx;
   assign det_forced = r_forced;
   assign state_o    = r_state;

endmodule

// File: tb/tb_mac_score_detector.sv
// -----------------------------------------------------------------------------
// tb_mac_score_detector
// Directed stimulus against a sample-level model of the detector. The model
// keeps the last WIN scores and sums them directly, and describes the event
// life cycle with plain flags and a countdown; a negedge process compares the
// DUT against it every cycle. Literal checks pin the model to known answers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_score_detector;
   import sdr_sync_pkg::*;

   localparam int SUM_W    = 22;
   localparam int WIN_LOG2 = 2;
   localparam int WIN      = 4;
   localparam int ACC_W    = SUM_W + WIN_LOG2;
   localparam int TH       = 100;
   localparam int HOLD     = 5;
   localparam int MAXT     = 8;

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             sum_valid = 1'b0;
   logic [SUM_W-1:0] sum_in    = '0;
   logic             det_ready = 1'b0;
   logic             det_valid;
   logic [ACC_W-1:0] det_peak;
   logic [15:0]      det_index;
   logic             det_forced;
   logic [2:0]       state_o;

   int n_checks = 0;
   int n_errors = 0;

   mac_score_detector #(
      .SUM_W     (SUM_W),
      .WIN_LOG2  (WIN_LOG2),
      .THRESH    (24'd100),
      .HOLDOFF   (HOLD),
      .MAX_TRACK (MAXT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sum_valid  (sum_valid),
      .sum_in     (sum_in),
      .det_valid  (det_valid),
      .det_ready  (det_ready),
      .det_peak   (det_peak),
      .det_index  (det_index),
      .det_forced (det_forced),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic summary_and_finish();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
         if (n_errors >= 100) summary_and_finish();
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned m_hist[$];
   int          m_idx;
   bit          m_pend;
   int          m_pend_sum, m_pend_idx;
   bit          m_armed, m_tracking, m_report, m_forced, m_clean;
   int          m_peak, m_peak_idx, m_len, m_quiet;

   task automatic model_step();
      int s;
      if (rst) begin
         m_hist.delete();
         m_idx = 0; m_pend = 0; m_pend_sum = 0; m_pend_idx = 0;
         m_armed = 0; m_tracking = 0; m_report = 0; m_forced = 0; m_clean = 1;
         m_peak = 0; m_peak_idx = 0; m_len = 0; m_quiet = 0;
         return;
      end
      // Decision on the sample accepted at the previous edge.
      if (m_report) begin
         if (det_ready) begin
            m_report = 0;
            m_quiet  = HOLD;
         end
      end else if (m_pend) begin
         m_armed = 1;
         if (m_quiet > 0) begin
            m_quiet--;
         end else if (m_tracking) begin
            if (m_pend_sum < TH) begin
               m_tracking = 0; m_report = 1; m_forced = 0;
            end else begin
               if (m_pend_sum > m_peak) begin
                  m_peak = m_pend_sum; m_peak_idx = m_pend_idx;
               end
               m_len++;
               if (m_len >= MAXT) begin
                  m_tracking = 0; m_report = 1; m_forced = 1;
               end
            end
         end else if (m_pend_sum >= TH) begin
            m_tracking = 1; m_clean = 0;
            m_peak = m_pend_sum; m_peak_idx = m_pend_idx; m_len = 1;
         end
      end
      // New sample at this edge: window sum by direct summation.
      if (sum_valid) begin
         m_hist.push_back(int'(sum_in));
         if (m_hist.size() > WIN) void'(m_hist.pop_front());
         s = 0;
         foreach (m_hist[k]) s += int'(m_hist[k]);
         m_pend     = (m_hist.size() == WIN);
         m_pend_sum = s;
         m_pend_idx = m_idx;
         m_idx      = (m_idx + 1) % 65536;
      end else begin
         m_pend = 0;
      end
   endtask

   function automatic logic [2:0] exp_state();
      if (!m_armed)   return ST_FILL;
      if (m_report)   return ST_REPORT;
      if (m_tracking) return ST_TRACK;
      if (m_quiet > 0) return ST_HOLDOFF;
      return ST_SEARCH;
   endfunction

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      check("det_valid", det_valid, m_report);
      check("state_o", state_o, exp_state());
      if (m_report || m_clean) begin
         check("det_peak",   det_peak,   m_report ? m_peak     : 0);
         check("det_index",  det_index,  m_report ? m_peak_idx : 0);
         check("det_forced", det_forced, m_report ? m_forced   : 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic feed(input int v);
      sum_valid = 1'b1;
      sum_in    = SUM_W'(v);
      @(negedge clk);
      sum_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      sum_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic ack();
      det_ready = 1'b1;
      sum_valid = 1'b0;
      @(negedge clk);
      det_ready = 1'b0;
   endtask

   task automatic pulse_reset(input string tag);
      rst       = 1'b1;
      sum_valid = 1'b0;
      det_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check({tag, "_valid"}, det_valid, 0);
      check({tag, "_state"}, state_o, ST_FILL);
      check({tag, "_index"}, det_index, 0);
   endtask

   task automatic check_report(input string tag, input int peak, input int idx, input bit forced);
      check({tag, "_valid"},  det_valid,  1);
      check({tag, "_peak"},   det_peak,   peak);
      check({tag, "_index"},  det_index,  idx);
      check({tag, "_forced"}, det_forced, forced);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset_valid",  det_valid,  0);
      check("reset_state",  state_o,    ST_FILL);
      check("reset_peak",   det_peak,   0);
      check("reset_index",  det_index,  0);
      check("reset_forced", det_forced, 0);
      rst = 1'b0;

      // Constant 10: window settles at 40, never reaches threshold.
      repeat (50) feed(10);
      idle(2);
      check("quiet_state", state_o, ST_SEARCH);
      check("quiet_valid", det_valid, 0);

      // Pulse of four 50s: peak 200 at index 7, ends below threshold.
      pulse_reset("rst1");
      repeat (4) feed(0);
      repeat (4) feed(50);
      repeat (6) feed(0);
      check_report("pulse", 200, 7, 1'b0);
      ack();
      check("pulse_holdoff", state_o, ST_HOLDOFF);
      // Five samples swallowed (14..18), TRACK from 19, forced after 8.
      repeat (HOLD + MAXT + 1) feed(50);
      check_report("rearm", 200, 19, 1'b1);

      // Constant 50 from reset: forced report, peak at index 3.
      pulse_reset("rst2");
      repeat (12) feed(50);
      check_report("forced", 200, 3, 1'b1);

      // Ready withheld for 20 above-threshold samples: report is frozen.
      repeat (20) feed(50);
      check_report("stall", 200, 3, 1'b1);
      check("stall_state", state_o, ST_REPORT);
      ack();
      repeat (HOLD - 1) feed(50);
      idle(2);
      check("hold_partial", state_o, ST_HOLDOFF);
      feed(50);
      idle(2);
      check("hold_done", state_o, ST_SEARCH);
      feed(50);
      idle(2);
      check("hold_retrack", state_o, ST_TRACK);

      // Reset while tracking; no compares until the window refills.
      pulse_reset("rst_track");
      repeat (3) feed(50);
      idle(2);
      check("refill_state", state_o, ST_FILL);
      feed(50);
      idle(2);
      check("refill_track", state_o, ST_TRACK);
      repeat (6) feed(0);
      check_report("refill", 200, 3, 1'b0);

      // Reset while a report is pending drops it.
      pulse_reset("rst_report");

      // Index wrap: event lands at raw index 65543 -> 7.
      repeat (65540) feed(0);
      repeat (4) feed(50);
      repeat (6) feed(0);
      check_report("wrap", 200, 7, 1'b0);
      ack();
      idle(3);

      summary_and_finish();
   end

endmodule
